// File: rtl/tlb_pkg.sv
// Shared types and sizing helpers for the TLB line-refill sequencer.
package tlb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned BANK_NUM_DEF   = 4;
  localparam int unsigned DATA_WIDTH_DEF = 64;

  // Two bank words travel per memory beat.
  function automatic int unsigned beats_of(input int unsigned bank_num);
    return bank_num / 2;
  endfunction

  function automatic int unsigned beat_cnt_w(input int unsigned beats);
    return (beats > 1) ? int'($clog2(beats)) : 1;
  endfunction

  function automatic int unsigned beat_stride(input int unsigned data_width);
    return (2 * data_width) / 8;
  endfunction

  localparam int unsigned BEATS       = beats_of(BANK_NUM_DEF);
  localparam int unsigned BEAT_CNT_W  = beat_cnt_w(BEATS);
  localparam int unsigned BEAT_STRIDE = beat_stride(DATA_WIDTH_DEF);

endpackage

// File: rtl/tlb_rr_arb.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module tlb_rr_arb (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant_c
);

  // Resets to 1 so requester 0 wins the first tie.
  logic last_q;

  always_comb begin
    grant_c = req;
    if (req == 2'b11) begin
      grant_c = last_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_q <= 1'b1;
    end else if (advance && (|grant_c)) begin
      last_q <= grant_c[1];
    end
  end

endmodule

// File: rtl/tlb_refill_arbiter.sv
// Refill sequencer for ITLB/DTLB sharing one wide memory read port.
// Optional performance counters are built when TLB_REFILL_PERF_EN is defined.
module tlb_refill_arbiter
  import tlb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BANK_NUM   = 4
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [1:0]                        miss_tlb,
  input  logic [1:0][ADDR_WIDTH-1:0]        addr_tlb,
  input  logic [1:0]                        set_tlb,
  output logic [1:0]                        busy_rd,
  output logic [ADDR_WIDTH-1:0]             addr_rd,
  output logic [2*DATA_WIDTH-1:0]           data_rd,
  output logic                              set_rd,
  output logic [1:0]                        wen_rd,
  output logic [1:0]                        finish_rd,
  input  logic                              satp_change,
  output logic                              mem_req,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  input  logic                              mem_gnt,
  input  logic                              mem_rvalid,
  input  logic [2*DATA_WIDTH-1:0]           mem_rdata
`ifdef TLB_REFILL_PERF_EN
  ,
  output logic [31:0]                       perf_refill_cnt0,
  output logic [31:0]                       perf_refill_cnt1,
  output logic [31:0]                       perf_abort_cnt,
  output logic [31:0]                       perf_wait_cnt
`endif
);

  localparam int unsigned NBEATS = beats_of(BANK_NUM);
  localparam int unsigned CNT_W  = beat_cnt_w(NBEATS);
  localparam int unsigned STRIDE = beat_stride(DATA_WIDTH);
  localparam int unsigned BEAT_W = 2 * DATA_WIDTH;

  state_e                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic                    way_q, way_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    last_q, last_d;
  logic                    abort_q, abort_d;
  logic                    mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [1:0]              busy_q, busy_d;
  logic [1:0]              wen_q, wen_d;
  logic [1:0]              fin_q, fin_d;
  logic [ADDR_WIDTH-1:0]   addr_rd_q, addr_rd_d;
  logic [BEAT_W-1:0]       data_rd_q, data_rd_d;
  logic                    set_rd_q, set_rd_d;

  logic [1:0]              grant_c;
  logic                    advance_c;
  logic                    owner_c;
  logic                    abort_now_c;

  tlb_rr_arb u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (miss_tlb),
    .advance (advance_c),
    .grant_c (grant_c)
  );

  assign owner_c = grant_c[1];

  // A context change seen this cycle already suppresses strobes computed now.
  assign abort_now_c = abort_q |
                       (satp_change && ((state_q == REQ) || (state_q == DATA)));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // last_q marks that the final beat sits in the output stage, so the finish
  // pulse lands exactly one cycle after the last write strobe.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    base_d     = base_q;
    way_d      = way_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    abort_d    = abort_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    wen_d      = 2'b00;
    fin_d      = 2'b00;
    addr_rd_d  = addr_rd_q;
    data_rd_d  = data_rd_q;
    set_rd_d   = set_rd_q;
    advance_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        last_d  = 1'b0;
        cnt_d   = '0;
        if ((|miss_tlb) && !satp_change) begin
          advance_c  = 1'b1;
          owner_d    = owner_c;
          base_d     = addr_tlb[owner_c];
          way_d      = set_tlb[owner_c];
          mem_req_d  = 1'b1;
          mem_addr_d = addr_tlb[owner_c];
          state_d    = REQ;
        end
      end
      REQ: begin
        abort_d = abort_now_c;
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          cnt_d     = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        abort_d = abort_now_c;
        if (last_q) begin
          fin_d[owner_q] = ~abort_now_c;
          state_d        = DONE;
        end else if (mem_rvalid) begin
          data_rd_d      = mem_rdata;
          addr_rd_d      = base_q + ADDR_WIDTH'(cnt_q) * ADDR_WIDTH'(STRIDE);
          set_rd_d       = way_q;
          wen_d[owner_q] = ~abort_now_c;
          if (cnt_q == CNT_W'(NBEATS - 1)) begin
            last_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE) ? 2'b11 : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      owner_q    <= 1'b0;
      base_q     <= '0;
      way_q      <= 1'b0;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      abort_q    <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 2'b00;
      wen_q      <= 2'b00;
      fin_q      <= 2'b00;
      addr_rd_q  <= '0;
      data_rd_q  <= '0;
      set_rd_q   <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      base_q     <= base_d;
      way_q      <= way_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      abort_q    <= abort_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      wen_q      <= wen_d;
      fin_q      <= fin_d;
      addr_rd_q  <= addr_rd_d;
      data_rd_q  <= data_rd_d;
      set_rd_q   <= set_rd_d;
    end
  end

  assign busy_rd   = busy_q;
  assign addr_rd   = addr_rd_q;
  assign data_rd   = data_rd_q;
  assign set_rd    = set_rd_q;
  assign wen_rd    = wen_q;
  assign finish_rd = fin_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;

`ifdef TLB_REFILL_PERF_EN
  logic [31:0] refill0_q, refill1_q, abort_cnt_q, wait_cnt_q;

  // Free-running event counters, wrapping naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      refill0_q   <= '0;
      refill1_q   <= '0;
      abort_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      if (fin_q[0]) refill0_q <= refill0_q + 32'd1;
      if (fin_q[1]) refill1_q <= refill1_q + 32'd1;
      if ((state_q == DONE) && abort_q) abort_cnt_q <= abort_cnt_q + 32'd1;
      if ((state_q == REQ) && !mem_gnt) wait_cnt_q <= wait_cnt_q + 32'd1;
    end
  end

  assign perf_refill_cnt0 = refill0_q;
  assign perf_refill_cnt1 = refill1_q;
  assign perf_abort_cnt   = abort_cnt_q;
  assign perf_wait_cnt    = wait_cnt_q;
`endif

endmodule

// File: tb/tb_tlb_refill_arbiter.sv
// Directed self-checking bench for tlb_refill_arbiter (default parameters).
module tb_tlb_refill_arbiter;

  logic              clk = 1'b0;
  logic              rstn;
  logic [1:0]        miss_tlb;
  logic [1:0][63:0]  addr_tlb;
  logic [1:0]        set_tlb;
  logic [1:0]        busy_rd;
  logic [63:0]       addr_rd;
  logic [127:0]      data_rd;
  logic              set_rd;
  logic [1:0]        wen_rd;
  logic [1:0]        finish_rd;
  logic              satp_change;
  logic              mem_req;
  logic [63:0]       mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [127:0]      mem_rdata;
`ifdef TLB_REFILL_PERF_EN
  logic [31:0]       perf_refill_cnt0, perf_refill_cnt1, perf_abort_cnt, perf_wait_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] fin_seen, wen_seen;
  logic       overlap, timed_out;

  always #5 clk = ~clk;

  tlb_refill_arbiter dut (
    .clk         (clk),
    .rstn        (rstn),
    .miss_tlb    (miss_tlb),
    .addr_tlb    (addr_tlb),
    .set_tlb     (set_tlb),
    .busy_rd     (busy_rd),
    .addr_rd     (addr_rd),
    .data_rd     (data_rd),
    .set_rd      (set_rd),
    .wen_rd      (wen_rd),
    .finish_rd   (finish_rd),
    .satp_change (satp_change),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
`ifdef TLB_REFILL_PERF_EN
    ,
    .perf_refill_cnt0 (perf_refill_cnt0),
    .perf_refill_cnt1 (perf_refill_cnt1),
    .perf_abort_cnt   (perf_abort_cnt),
    .perf_wait_cnt    (perf_wait_cnt)
`endif
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn        = 1'b0;
    miss_tlb    = 2'b00;
    addr_tlb    = '0;
    set_tlb     = 2'b00;
    satp_change = 1'b0;
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    tick();
    rstn = 1'b1;
  endtask

  // Zero-wait memory responder; runs until busy_rd drops or the budget expires.
  task automatic serve(output logic [1:0] fs, output logic [1:0] ws,
                       output logic ov, output logic to);
    logic granted;
    int   sent;
    granted = 1'b0;
    sent    = 0;
    fs = 2'b00; ws = 2'b00; ov = 1'b0; to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      fs |= finish_rd;
      ws |= wen_rd;
      if ((|finish_rd) && (|wen_rd)) ov = 1'b1;
      if (i > 0 && busy_rd == 2'b00) begin
        to = 1'b0;
        break;
      end
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (!granted && mem_req) begin
        mem_gnt = 1'b1;
        granted = 1'b1;
      end else if (granted && sent < 2) begin
        mem_rvalid = 1'b1;
        mem_rdata  = {64'hCAFE_0000_0000_0000, 64'(sent)};
        sent++;
      end
      tick();
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    n_cmp++;
    if (busy_rd !== 2'b00 || wen_rd !== 2'b00 || finish_rd !== 2'b00) begin
      n_err++;
      $display("FAIL reset_strobes: busy=%b wen=%b fin=%b expected 00 00 00", busy_rd, wen_rd, finish_rd);
    end
    n_cmp++;
    if (mem_req !== 1'b0 || mem_addr !== 64'd0) begin
      n_err++;
      $display("FAIL reset_mem: req=%b addr=%h expected 0 0", mem_req, mem_addr);
    end
    n_cmp++;
    if (addr_rd !== 64'd0 || data_rd !== 128'd0 || set_rd !== 1'b0) begin
      n_err++;
      $display("FAIL reset_refill_bus: addr=%h data=%h set=%b expected 0", addr_rd, data_rd, set_rd);
    end
  endtask

  task automatic test_single_itlb();
    miss_tlb    = 2'b01;
    addr_tlb[0] = 64'h8000_0040;
    set_tlb     = 2'b01;
    tick();
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h8000_0040 || busy_rd !== 2'b11) begin
      n_err++;
      $display("FAIL single_req: req=%b addr=%h busy=%b expected 1 80000040 11", mem_req, mem_addr, busy_rd);
    end
    miss_tlb = 2'b00;
    mem_gnt  = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    n_cmp++;
    if (mem_req !== 1'b0 || wen_rd !== 2'b00) begin
      n_err++;
      $display("FAIL single_gnt: req=%b wen=%b expected 0 00", mem_req, wen_rd);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    tick();
    n_cmp++;
    if (wen_rd !== 2'b01 || addr_rd !== 64'h8000_0040 || set_rd !== 1'b1 ||
        data_rd !== 128'h1111_2222_3333_4444_5555_6666_7777_8888 || finish_rd !== 2'b00) begin
      n_err++;
      $display("FAIL single_beat0: wen=%b addr=%h set=%b data=%h fin=%b expected 01 80000040 1 1111..8888 00",
               wen_rd, addr_rd, set_rd, data_rd, finish_rd);
    end
    mem_rdata = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
    tick();
    mem_rvalid = 1'b0;
    n_cmp++;
    if (wen_rd !== 2'b01 || addr_rd !== 64'h8000_0050 ||
        data_rd !== 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000) begin
      n_err++;
      $display("FAIL single_beat1: wen=%b addr=%h data=%h expected 01 80000050 9999..0000", wen_rd, addr_rd, data_rd);
    end
    tick();
    n_cmp++;
    if (finish_rd !== 2'b01 || wen_rd !== 2'b00 || busy_rd !== 2'b11) begin
      n_err++;
      $display("FAIL single_finish: fin=%b wen=%b busy=%b expected 01 00 11", finish_rd, wen_rd, busy_rd);
    end
    tick();
    n_cmp++;
    if (finish_rd !== 2'b00 || busy_rd !== 2'b00) begin
      n_err++;
      $display("FAIL single_idle: fin=%b busy=%b expected 00 00", finish_rd, busy_rd);
    end
  endtask

  task automatic test_arbitration();
    do_reset();
    miss_tlb    = 2'b11;
    addr_tlb[0] = 64'h1000;
    addr_tlb[1] = 64'h2000;
    set_tlb     = 2'b10;
    tick();
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h1000) begin
      n_err++;
      $display("FAIL arb_first: req=%b addr=%h expected 1 1000", mem_req, mem_addr);
    end
    miss_tlb = 2'b10;
    serve(fin_seen, wen_seen, overlap, timed_out);
    n_cmp++;
    if (timed_out !== 1'b0 || fin_seen !== 2'b01 || wen_seen !== 2'b01 || overlap !== 1'b0) begin
      n_err++;
      $display("FAIL arb_first_refill: to=%b fin=%b wen=%b ov=%b expected 0 01 01 0", timed_out, fin_seen, wen_seen, overlap);
    end
    tick();
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h2000) begin
      n_err++;
      $display("FAIL arb_second: req=%b addr=%h expected 1 2000", mem_req, mem_addr);
    end
    miss_tlb = 2'b00;
    serve(fin_seen, wen_seen, overlap, timed_out);
    n_cmp++;
    if (timed_out !== 1'b0 || fin_seen !== 2'b10 || wen_seen !== 2'b10 || overlap !== 1'b0) begin
      n_err++;
      $display("FAIL arb_second_refill: to=%b fin=%b wen=%b ov=%b expected 0 10 10 0", timed_out, fin_seen, wen_seen, overlap);
    end
    miss_tlb = 2'b11;
    tick();
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h1000) begin
      n_err++;
      $display("FAIL arb_third: req=%b addr=%h expected 1 1000", mem_req, mem_addr);
    end
    miss_tlb = 2'b00;
    serve(fin_seen, wen_seen, overlap, timed_out);
    n_cmp++;
    if (timed_out !== 1'b0 || fin_seen !== 2'b01) begin
      n_err++;
      $display("FAIL arb_third_refill: to=%b fin=%b expected 0 01", timed_out, fin_seen);
    end
  endtask

  task automatic test_gnt_wait();
    int bad;
    do_reset();
    miss_tlb    = 2'b01;
    addr_tlb[0] = 64'h3000;
    tick();
    miss_tlb = 2'b00;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_req !== 1'b1 || mem_addr !== 64'h3000 || wen_rd !== 2'b00) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL wait_stable: %0d unstable cycles expected 0", bad);
    end
    serve(fin_seen, wen_seen, overlap, timed_out);
    n_cmp++;
    if (timed_out !== 1'b0 || fin_seen !== 2'b01 || wen_seen !== 2'b01) begin
      n_err++;
      $display("FAIL wait_refill: to=%b fin=%b wen=%b expected 0 01 01", timed_out, fin_seen, wen_seen);
    end
`ifdef TLB_REFILL_PERF_EN
    n_cmp++;
    if (perf_wait_cnt !== 32'd5 || perf_refill_cnt0 !== 32'd1) begin
      n_err++;
      $display("FAIL perf_wait: wait=%0d refill0=%0d expected 5 1", perf_wait_cnt, perf_refill_cnt0);
    end
`endif
  endtask

  task automatic test_abort();
    logic fin_any;
    logic done;
    do_reset();
    miss_tlb    = 2'b10;
    addr_tlb[1] = 64'h4000;
    set_tlb     = 2'b00;
    tick();
    miss_tlb = 2'b00;
    mem_gnt  = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 128'hA0;
    tick();
    n_cmp++;
    if (wen_rd !== 2'b10 || addr_rd !== 64'h4000) begin
      n_err++;
      $display("FAIL abort_beat0: wen=%b addr=%h expected 10 4000", wen_rd, addr_rd);
    end
    mem_rvalid  = 1'b0;
    satp_change = 1'b1;
    tick();
    satp_change = 1'b0;
    mem_rvalid  = 1'b1;
    mem_rdata   = 128'hA1;
    tick();
    mem_rvalid = 1'b0;
    n_cmp++;
    if (wen_rd !== 2'b00) begin
      n_err++;
      $display("FAIL abort_beat1: wen=%b expected 00", wen_rd);
    end
    fin_any = 1'b0;
    done    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      fin_any |= |finish_rd;
      if (busy_rd == 2'b00) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    n_cmp++;
    if (done !== 1'b1 || fin_any !== 1'b0) begin
      n_err++;
      $display("FAIL abort_drain: idle=%b finish_seen=%b expected 1 0", done, fin_any);
    end
`ifdef TLB_REFILL_PERF_EN
    tick();
    n_cmp++;
    if (perf_abort_cnt !== 32'd1 || perf_refill_cnt1 !== 32'd0) begin
      n_err++;
      $display("FAIL perf_abort: abort=%0d refill1=%0d expected 1 0", perf_abort_cnt, perf_refill_cnt1);
    end
`endif
  endtask

  task automatic test_reset_mid();
    miss_tlb    = 2'b01;
    addr_tlb[0] = 64'h5000;
    set_tlb     = 2'b01;
    tick();
    miss_tlb = 2'b00;
    mem_gnt  = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 128'h55;
    tick();
    rstn = 1'b0;
    tick();
    rstn       = 1'b1;
    mem_rvalid = 1'b0;
    n_cmp++;
    if (busy_rd !== 2'b00 || wen_rd !== 2'b00 || finish_rd !== 2'b00 || mem_req !== 1'b0 ||
        mem_addr !== 64'd0 || addr_rd !== 64'd0 || data_rd !== 128'd0 || set_rd !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_outputs: busy=%b wen=%b fin=%b req=%b maddr=%h addr=%h data=%h set=%b expected all 0",
               busy_rd, wen_rd, finish_rd, mem_req, mem_addr, addr_rd, data_rd, set_rd);
    end
    miss_tlb    = 2'b10;
    addr_tlb[1] = 64'h6000;
    set_tlb     = 2'b10;
    tick();
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h6000) begin
      n_err++;
      $display("FAIL midreset_fresh_req: req=%b addr=%h expected 1 6000", mem_req, mem_addr);
    end
    miss_tlb = 2'b00;
    serve(fin_seen, wen_seen, overlap, timed_out);
    n_cmp++;
    if (timed_out !== 1'b0 || fin_seen !== 2'b10 || wen_seen !== 2'b10 || set_rd !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_fresh_refill: to=%b fin=%b wen=%b set=%b expected 0 10 10 1",
               timed_out, fin_seen, wen_seen, set_rd);
    end
  endtask

  task automatic test_spurious();
    int bad;
    bad        = 0;
    mem_rvalid = 1'b1;
    mem_rdata  = 128'hDEAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (wen_rd !== 2'b00 || busy_rd !== 2'b00 || mem_req !== 1'b0 || finish_rd !== 2'b00) bad++;
    end
    mem_rvalid = 1'b0;
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL spurious_rvalid: %0d cycles with activity expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_itlb();
    test_arbitration();
    test_gnt_wait();
    test_abort();
    test_reset_mid();
    test_spurious();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
